// File: rtl/relu_maxpool_32_2.sv
// ReLU(max-pool over P-word windows) on a streaming signed conv output, one result per window.
// Latency: result valid 1 cycle after the last word of its window is accepted.
// Backpressure: 2-entry output FIFO; x_ready drops only on a window's last word while the FIFO is full.
module relu_maxpool_32_2 #(
    parameter int T = 16,
    parameter int N = 32,
    parameter int P = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [T-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready
);

    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int VW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] pos;
    logic [VW-1:0] vec_cnt;
    logic [T-1:0]  run_max;
    logic [T-1:0]  fifo0;
    logic [T-1:0]  fifo1;
    logic [1:0]    count;

    logic          pos_last;
    logic          vec_last;
    logic          x_fire;
    logic          y_fire;
    logic          push;
    logic [T-1:0]  win_max;
    logic [T-1:0]  result;

    assign pos_last = (pos == PW'(P - 1));
    assign vec_last = (vec_cnt == VW'(N - 1));

    // x_ready depends only on registered state and reset, never on y_ready.
    assign x_ready  = reset && (!pos_last || (count != 2'd2));
    assign x_fire   = x_valid && x_ready;
    assign y_valid  = (count != 2'd0);
    assign y_fire   = y_valid && y_ready;
    assign push     = x_fire && pos_last;
    assign y_data   = fifo0;

    // Running max including the incoming word; position 0 restarts the window.
    assign win_max  = ((pos == '0) || ($signed(x_data) > $signed(run_max))) ? x_data : run_max;
    assign result   = win_max[T-1] ? '0 : win_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos     <= '0;
            vec_cnt <= '0;
            run_max <= '0;
        end else if (x_fire) begin
            pos     <= pos_last ? '0 : pos + PW'(1);
            vec_cnt <= vec_last ? '0 : vec_cnt + VW'(1);
            run_max <= win_max;
        end
    end

    // fifo0 is always the head so y_data comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            fifo0 <= '0;
            fifo1 <= '0;
        end else begin
            case ({push, y_fire})
                2'b10: begin
                    if (count == 2'd0) fifo0 <= result;
                    else               fifo1 <= result;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    fifo0 <= fifo1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        fifo0 <= result;
                    end else begin
                        fifo0 <= fifo1;
                        fifo1 <= result;
                    end
                end
                default: ;
            endcase
        end
    end

    // A vector must always end on a window boundary.
    always_ff @(posedge clk) begin
        if (reset && x_fire && vec_last) assert (pos_last);
    end

endmodule

// File: doc/relu_maxpool_32_2.md
RELU_MAXPOOL_32_2 -- requirements
Module: relu_maxpool_32_2

Interface
REQ-001 Parameter T, default 16: data word width in bits, signed two's complement.
REQ-002 Parameter N, default 32: input vector length in words, equal to the conv_96_65 output vector length 96-65+1.
REQ-003 Parameter P, default 2: pooling window size and stride in words; N SHALL be an integer multiple of P, with P >= 2.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 x_data  input  T  signed input word, taken from the conv output stream.
REQ-007 x_valid  input  1  upstream has a word on x_data.
REQ-008 x_ready  output  1  block accepts x_data this cycle.
REQ-009 y_data  output  T  signed pooled, ReLU-clipped result.
REQ-010 y_valid  output  1  y_data holds a valid result.
REQ-011 y_ready  input  1  downstream accepts y_data this cycle.

Function
REQ-012 An input transfer occurs on a rising clk edge with x_valid=1 and x_ready=1; an output transfer occurs on a rising edge with y_valid=1 and y_ready=1.
REQ-013 Input words are grouped into consecutive non-overlapping windows of P words; window k covers input words k*P .. k*P+P-1 of the current vector.
REQ-014 Within a window, a running-max register SHALL load the first accepted word and, on each later word, keep the signed maximum of its current value and the new word.
REQ-015 Each window SHALL produce exactly one output equal to max(window maximum, 0): ReLU applied after pooling, with no other saturation or width change.
REQ-016 The block SHALL emit N/P outputs per N-word input vector, in input order, and process vectors back-to-back with no gap or marker.
REQ-017 Position counter pos: range 0..P-1; increments on each input transfer; wraps from P-1 to 0.
REQ-018 Vector counter: range 0..N-1; wraps to 0 after word N-1; used only for window alignment checking, with no output effect beyond REQ-016.
REQ-019 Outputs SHALL be buffered in a 2-entry FIFO (count range 0..2); y_valid=1 exactly when count>0; y_data SHALL be the oldest entry, driven directly from a register.
REQ-020 When pos<P-1, x_ready SHALL be 1 (no output is produced).
REQ-021 When pos=P-1, x_ready SHALL be 1 only if FIFO count<2; there is no combinational path from y_ready to x_ready.
REQ-022 When the last word of a window is transferred, the result SHALL be written to the FIFO in the same edge and be visible on y_valid/y_data at the next cycle (latency 1 cycle from last-window-word transfer to y_valid).
REQ-023 Simultaneous push and pop in one edge SHALL leave count unchanged, keep FIFO order, and lose no data.
REQ-024 With x_valid=1 and y_ready=1 held continuously, throughput SHALL be one input word per cycle with no stalls.
REQ-025 While y_valid=1 and y_ready=0, y_data SHALL remain stable.
REQ-026 x_data SHALL be ignored (may be X) whenever no input transfer occurs.
REQ-027 Signed compare: 16'h8000 is the minimum value; equal values select either (identical result).

Reset
REQ-028 While reset=0, asynchronously: pos=0, vector counter=0, FIFO count=0, y_valid=0, running-max cleared to 0, x_ready=0.
REQ-029 y_data after reset SHALL be 0.
REQ-030 The first rising edge after reset deasserts SHALL treat the next accepted word as window position 0; a partial window in progress at reset SHALL be discarded.
REQ-031 Reset asserted mid-stream SHALL drop all buffered outputs; no output from pre-reset input SHALL appear afterwards.

Verification
REQ-032 Scenario 1: input words 5, -3, -7, -2 with y_ready=1 -> outputs 5, 0.
REQ-033 Scenario 2: one full vector of 32 words 0..31 (pairs) -> 16 outputs 1, 3, 5, ..., 31, in order.
REQ-034 Scenario 3: y_ready=0, stream 6 words 10, 20, 30, 40, 50, 60 -> y_data=20 held; x_ready=0 while pos=1 and count=2; after y_ready=1 outputs are 20, 40, 60 with none lost.
REQ-035 Scenario 4: input pair 16'h8000, 16'h8001 -> output 0; input pair 16'h7FFF, 16'h8000 -> output 16'h7FFF.
REQ-036 Scenario 5: random x_valid/y_ready (50% each, as in the conv bench) over 104 vectors -> all 1664 outputs match the golden model, with an error count of 0.
REQ-037 Scenario 6: reset=0 after 1 word of a window, with 1 result in the FIFO -> y_valid=0 immediately; the next 2 words after reset release form a fresh window.
